// File: rtl/sm4_pkg.sv
// sm4_pkg: shared state encoding, widths, defaults and SM4 standard test vectors
package sm4_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int SM4_W = 128;
  localparam int SM4_TIMEOUT = 127;
  localparam logic [127:0] SM4_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] SM4_PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] SM4_CT  = 128'h681edf34d206965e86b3e94f536e4246;
endpackage

// File: rtl/sm4_arb.sv
// sm4_arb: two-port round-robin front end for an external SM4 core, one job at a time with timeout
module sm4_arb
  import sm4_pkg::*;
#(
  parameter int TIMEOUT = SM4_TIMEOUT,
  parameter int W = SM4_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] key0,
  input  logic [W-1:0] key1,
  input  logic [1:0]   mode,
  output logic [1:0]   ack,
  output logic [1:0]   done,
  output logic         err,
  output logic [W-1:0] dout,
  output logic         core_start,
  output logic [W-1:0] core_data,
  output logic [W-1:0] core_mk,
  output logic         core_dec,
  input  logic [W-1:0] core_dataout,
  input  logic         core_valid
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic lp, owner, dec_r, win;
  logic [W-1:0] data_r, key_r;
  logic [TW-1:0] timer;
  assign win = &req ? ~lp : req[1];
  assign core_data = data_r;
  assign core_mk = key_r;
  assign core_dec = dec_r;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lp <= 1'b1;
      owner <= 1'b0;
      timer <= '0;
      data_r <= '0;
      key_r <= '0;
      dec_r <= 1'b0;
      dout <= '0;
      ack <= '0;
      done <= '0;
      err <= 1'b0;
      core_start <= 1'b0;
    end else begin
      ack <= '0;
      done <= '0;
      err <= 1'b0;
      core_start <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          owner <= win;
          data_r <= win ? din1 : din0;
          key_r <= win ? key1 : key0;
          dec_r <= mode[win];
          ack <= win ? 2'b10 : 2'b01;
          state <= ISSUE;
        end
        ISSUE: begin
          core_start <= 1'b1;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // a result arriving on the timeout cycle still counts as a success
          if (core_valid) begin
            dout <= core_dataout;
            done <= owner ? 2'b10 : 2'b01;
            state <= DONE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            dout <= '0;
            err <= 1'b1;
            done <= owner ? 2'b10 : 2'b01;
            state <= DONE;
          end
        end
        DONE: begin
          lp <= owner;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sm4_arb.sv
// tb_sm4_arb: randomized scoreboard bench with a behavioural SM4 core model
module tb_sm4_arb;
  import sm4_pkg::*;
  localparam int TO = SM4_TIMEOUT;
  typedef struct {
    logic port;
    logic [127:0] res;
    logic err;
    logic [127:0] d;
    logic [127:0] k;
    logic dec;
  } exp_t;
  logic clk, rst;
  logic [1:0] req, mode, ack, done;
  logic [127:0] din0, din1, key0, key1, dout, core_data, core_mk, core_dataout;
  logic err, core_start, core_dec, core_valid;
  sm4_arb #(.TIMEOUT(TO), .W(128)) dut (
    .clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1), .key0(key0), .key1(key1),
    .mode(mode), .ack(ack), .done(done), .err(err), .dout(dout), .core_start(core_start),
    .core_data(core_data), .core_mk(core_mk), .core_dec(core_dec),
    .core_dataout(core_dataout), .core_valid(core_valid)
  );
  int passed = 0, total = 0, ncyc = 0;
  int ack_cnt = 0, done_cnt = 0, starts = 0, ack_n = 0, start_n = 0, exp_ack_n = 0, valid_n = 0;
  logic [1:0] last_ack = '0;
  logic lp_m;
  exp_t q[$];
  exp_t e;
  int m_lat = 68, m_elapsed = 0;
  bit m_never = 0, m_busy = 0;
  logic [127:0] m_d, m_k;
  logic m_dec;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] x);
    total++;
    if (a === x) passed++;
    else $display("FAIL %s: got %h expected %h", nm, a, x);
  endtask
  task automatic tmo(input string nm);
    total++;
    $display("FAIL %s: bound expired waiting on DUT", nm);
  endtask

  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k, input logic dec);
    if (k == SM4_KEY && !dec && d == SM4_PT) return SM4_CT;
    if (k == SM4_KEY && dec && d == SM4_CT) return SM4_PT;
    return {d[63:0], d[127:64]} ^ k ^ {128{dec}};
  endfunction

  // behavioural core: fixed latency after the start pulse, junk on the bus otherwise
  initial begin
    core_valid = 0;
    core_dataout = '0;
    forever begin
      @(negedge clk);
      core_valid = 0;
      core_dataout = {$urandom, $urandom, $urandom, $urandom};
      if (m_busy) begin
        m_elapsed++;
        if (!m_never && m_elapsed == m_lat) begin
          core_valid = 1;
          core_dataout = core_fn(m_d, m_k, m_dec);
          m_busy = 0;
          valid_n = ncyc;
        end
      end
      if (core_start) begin
        m_busy = 1;
        m_elapsed = 0;
        m_d = core_data;
        m_k = core_mk;
        m_dec = core_dec;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (ack != 0) begin
      if (q.size() == 0) chk("ack_unexpected", ack, 2'b00);
      else begin
        chk("ack_port", ack, q[0].port ? 2'b10 : 2'b01);
        chk("ack_latency", ncyc, exp_ack_n);
      end
      last_ack = ack;
      ack_n = ncyc;
      starts = 0;
      ack_cnt++;
    end
    if (core_start) begin
      starts++;
      start_n = ncyc;
      if (q.size() != 0) begin
        chk("start_latency", ncyc, ack_n + 1);
        chk("core_data", core_data, q[0].d);
        chk("core_mk", core_mk, q[0].k);
        chk("core_dec", core_dec, q[0].dec);
      end
    end
    if (err && done == 0) chk("err_without_done", err, 1'b0);
    if (done != 0) begin
      if (q.size() == 0) chk("done_unexpected", done, 2'b00);
      else begin
        e = q.pop_front();
        chk("done_port", done, e.port ? 2'b10 : 2'b01);
        chk("err", err, e.err);
        chk("dout", dout, e.res);
        chk("starts_per_job", starts, 1);
        chk("done_time", ncyc, e.err ? start_n + TO : valid_n + 1);
      end
      done_cnt++;
      exp_ack_n = ncyc + 2;
    end
  end

  task automatic push_job(input logic w);
    exp_t x;
    x.port = w;
    x.d = w ? din1 : din0;
    x.k = w ? key1 : key0;
    x.dec = mode[w];
    x.err = m_never || m_lat > TO - 1;
    x.res = x.err ? '0 : core_fn(x.d, x.k, x.dec);
    q.push_back(x);
    lp_m = w;
  endtask

  task automatic job(input logic [1:0] r, input bit hold, input int njobs, input int lat_i, input bit never_i);
    logic [1:0] p;
    int a0, d0, n;
    m_lat = lat_i;
    m_never = never_i;
    p = r;
    for (int j = 0; j < njobs; j++) begin
      push_job(p == 2'b11 ? ~lp_m : p[1]);
      if (!hold) p[lp_m] = 1'b0;
    end
    @(negedge clk);
    #1;
    a0 = ack_cnt;
    d0 = done_cnt;
    exp_ack_n = ncyc + 1;
    req = r;
    for (int j = 0; j < njobs; j++) begin
      n = 0;
      while (ack_cnt <= a0 + j && n < 20) begin @(negedge clk); #1; n++; end
      if (ack_cnt <= a0 + j) tmo("ack_wait");
      req = (hold && j < njobs - 1) ? req : req & ~last_ack;
      if (hold && j == njobs - 1) req = 2'b00;
      n = 0;
      while (done_cnt <= d0 + j && n < 300) begin @(negedge clk); #1; n++; end
      if (done_cnt <= d0 + j) tmo("done_wait");
    end
    req = 2'b00;
  endtask

  task automatic rand_inputs();
    din0 = {$urandom, $urandom, $urandom, $urandom};
    din1 = {$urandom, $urandom, $urandom, $urandom};
    key0 = {$urandom, $urandom, $urandom, $urandom};
    key1 = {$urandom, $urandom, $urandom, $urandom};
    mode = 2'($urandom_range(0, 3));
  endtask

  initial begin
    int n, d0;
    logic [1:0] r;
    rst = 1;
    req = 0;
    lp_m = 1;
    rand_inputs();
    repeat (3) @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ack", ack, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_dout", dout, '0);
    chk("rst_core_data", core_data, '0);
    chk("rst_core_mk", core_mk, '0);
    chk("rst_core_dec", core_dec, 1'b0);
    din0 = SM4_PT; key0 = SM4_KEY; mode = 2'b00;
    job(2'b01, 0, 1, 68, 0);
    din1 = SM4_CT; key1 = SM4_KEY; mode = 2'b10;
    job(2'b10, 0, 1, 68, 0);
    job(2'b11, 1, 4, 68, 0);
    rand_inputs();
    job(2'b01, 0, 1, 68, 1);
    rand_inputs();
    job(2'b10, 0, 1, TO - 1, 0);
    rand_inputs();
    job(2'b10, 0, 1, TO, 0);
    for (int i = 0; i < 12; i++) begin
      rand_inputs();
      r = 2'($urandom_range(1, 3));
      job(r, 0, r == 2'b11 ? 2 : 1, $urandom_range(1, 90), 0);
    end
    // reset in the middle of a job, then let the abandoned core result arrive
    rand_inputs();
    m_lat = 68;
    m_never = 0;
    push_job(1'b0);
    @(negedge clk);
    #1;
    exp_ack_n = ncyc + 1;
    req = 2'b01;
    n = 0;
    while (!(m_busy && m_elapsed >= 30) && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) tmo("core_cycle_30");
    req = 2'b00;
    rst = 1;
    @(negedge clk);
    #1 rst = 0;
    q.delete();
    lp_m = 1;
    d0 = done_cnt;
    n = 0;
    while (m_busy && n < 100) begin @(negedge clk); #1; n++; end
    if (m_busy) tmo("stray_valid");
    repeat (3) @(negedge clk);
    chk("stray_dout", dout, '0);
    chk("stray_no_done", done_cnt, d0);
    rand_inputs();
    job(2'b01, 0, 1, 68, 0);
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sm4_arb.md
SM4_ARB -- requirements
Module: sm4_arb

Interface
REQ-001 Parameter TIMEOUT, default 127: maximum cycles spent in WAIT before a job is aborted.
REQ-002 Parameter W, default 128: block and key width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  2  request, bit n = port n.
REQ-006 din0 / din1  in  128 each  data block, ports 0 / 1.
REQ-007 key0 / key1  in  128 each  master key, ports 0 / 1.
REQ-008 mode  in  2  bit n: 1 = decrypt, 0 = encrypt, port n.
REQ-009 ack  out  2  one-cycle pulse; port n inputs captured.
REQ-010 done  out  2  one-cycle pulse; result for port n on dout.
REQ-011 err  out  1  one-cycle pulse with done; job timed out.
REQ-012 dout  out  128  result; held until next done.
REQ-013 core_start  out  1  one-cycle start to the SM4 core.
REQ-014 core_data / core_mk  out  128 each  block and key to the core.
REQ-015 core_dec  out  1  1 selects the decrypt core, 0 the encrypt core.
REQ-016 core_dataout  in  128  core result.
REQ-017 core_valid  in  1  core result-valid pulse.

Function
REQ-018 FSM states are IDLE, ISSUE, WAIT and DONE, with at most one job outstanding.
REQ-019 IDLE with req != 0: winner is the sole requester, or if both request, the port other than last-served pointer lp; latch din/key/mode of winner; ack[winner]=1 next cycle; go to ISSUE.
REQ-020 IDLE with req == 0 stays in IDLE; all pulses are 0.
REQ-021 ISSUE drives core_start=1 for exactly one cycle, clears the wait timer and goes to WAIT.
REQ-022 core_data, core_mk and core_dec come from the latched registers and are stable from ISSUE through DONE.
REQ-023 In WAIT the timer increments each cycle.
  - core_valid=1: capture core_dataout into dout and go to DONE.
  - Timer == TIMEOUT-1 without core_valid: set the abort flag, dout=0, go to DONE.
  - core_valid on the same cycle as the timeout: valid wins and the job is not aborted.
REQ-024 DONE asserts done[owner]=1 and err=abort flag for one cycle, sets lp=owner and returns to IDLE.
REQ-025 core_valid outside WAIT is ignored; dout is unchanged.
REQ-026 A req still high after ack is a new request and is arbitrated in the next IDLE (the requester drops req on ack).
REQ-027 req falling before ack: no ack, no job.
REQ-028 Latency:
  - req sampled in IDLE -> ack 1 cycle later.
  - ack -> core_start 1 cycle later.
  - core_valid -> done 1 cycle later.
REQ-029 Timer width is ceil(log2(TIMEOUT+1)) and the timer does not wrap within a job.

Reset
REQ-030 rst=1 forces state IDLE and lp=1 (port 0 wins the first tie).
REQ-031 rst=1 clears timer, abort flag, latched data/key/mode, dout, ack, done, err and core_start to 0.
REQ-032 Reset mid-job abandons the job silently: no done and no err; a later stray core_valid is ignored per REQ-025.

Structure
REQ-033 Shared package sm4_pkg holds the state encoding, W, the TIMEOUT default and the SM4 test-vector constants.
REQ-034 The round-robin pick stays inline; no sub-module is needed; SM4 cores are instantiated outside this block.

Verification
REQ-035 Bench uses a behavioural core model with configurable latency (default 68 cycles) and SM4 standard vectors.
REQ-036 Port-0 encrypt, key=din0=0123456789abcdeffedcba9876543210 -> ack=01, one core_start, done=01, dout=681edf34d206965e86b3e94f536e4246, err=0.
REQ-037 Port-1 decrypt of 681edf34d206965e86b3e94f536e4246 with the same key -> core_dec=1, done=10, dout=0123456789abcdeffedcba9876543210.
REQ-038 req=11 held continuously for 4 jobs -> grants 0,1,0,1 and exactly one core_start per job.
REQ-039 Model never asserts core_valid -> done pulse exactly TIMEOUT cycles after WAIT entry, err=1, dout=0.
REQ-040 rst=1 for one cycle at core-model cycle 30, then req=01 -> no done from the first job, the new job completes normally, and the stray core_valid is ignored.
